// File: rtl/tick_sched.sv
// Tick scheduler: single-cycle enable pulses at a switch-selected rate, with run/pause and step.
// Optional heartbeat output enabled by defining TICK_SCHED_HEARTBEAT_EN.
module tick_sched #(
  parameter int unsigned BASE_PERIOD = 12_500_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] speed,
  output logic       tick,
  output logic       running,
  output logic [7:0] tick_cnt,
  output logic       hb
);

  typedef enum logic [1:0] {StPause, StRun, StStep} state_e;

  localparam logic [CNT_W-1:0] BasePeriod = CNT_W'(BASE_PERIOD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] period_sel;
  logic             step_q;
  logic             step_rise;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;

  assign period_sel = BasePeriod << speed;
  assign step_rise  = step & ~step_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    tick_d   = 1'b0;
    unique case (state_q)
      StPause: begin
        cnt_d = '0;
        // run has priority; a simultaneous step edge is dropped
        if (run) begin
          state_d  = StRun;
          period_d = period_sel;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
      StStep: begin
        tick_d  = 1'b1;
        state_d = StPause;
      end
      StRun: begin
        // speed is only re-latched at a period boundary
        if (cnt_q == period_q - 1'b1) begin
          cnt_d    = '0;
          tick_d   = 1'b1;
          period_d = period_sel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!run) begin
          state_d = StPause;
          cnt_d   = '0;
        end
      end
      default: state_d = StPause;
    endcase
    running_d  = (state_d == StRun);
    tick_cnt_d = tick_cnt_q + {7'd0, tick_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StPause;
      cnt_q      <= '0;
      period_q   <= BasePeriod;
      step_q     <= 1'b1;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      tick_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      step_q     <= step;
      tick_q     <= tick_d;
      running_q  <= running_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick     = tick_q;
  assign running  = running_q;
  assign tick_cnt = tick_cnt_q;

`ifdef TICK_SCHED_HEARTBEAT_EN
  logic hb_q, hb_d;

  assign hb_d = tick_d ? ~hb_q : hb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hb_q <= 1'b0;
    end else begin
      hb_q <= hb_d;
    end
  end

  assign hb = hb_q;
`else
  assign hb = 1'b0;
`endif

endmodule
